// File: rtl/loader_pkg.sv
// Shared definitions for the serial boot/debug loader: FSM state encoding,
// command bytes, response bytes and the default packet sync marker.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR_H,
        ADDR_L,
        LEN,
        DATA,
        CSUM,
        RESP
    } state_t;

    localparam logic [7:0] CMD_LOAD     = 8'h4C;
    localparam logic [7:0] CMD_GO       = 8'h47;
    localparam logic [7:0] CMD_HOLD     = 8'h48;
    localparam logic [7:0] ACK          = 8'h06;
    localparam logic [7:0] NAK          = 8'h15;
    localparam logic [7:0] SYNC_DEFAULT = 8'h55;

endpackage

// File: rtl/loader_timeout.sv
// Inter-byte timeout counter for the loader.
// Ports: clk, reset (async, active-high), reload (restart the count),
// enable (count while high), expired (count reached timeout_cycles while enabled).
module loader_timeout #(
    parameter int timeout_cycles = 1600000
) (
    input  logic clk,
    input  logic reset,
    input  logic reload,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(timeout_cycles + 1);

    logic [W-1:0] cnt;
    logic         at_limit;

    assign at_limit = (cnt == W'(timeout_cycles));
    assign expired  = enable && at_limit;

    // Saturates at the limit so a long stall cannot wrap back to zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= '0;
        end else if (enable && !at_limit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_loader.sv
// Serial loader: parses 55/cmd framed packets from the receiver byte stream,
// writes payload into memory, returns ACK/NAK and controls CPU hold.
// Ports: clk, reset (async, active-high); rx_dat/rx_stb/rx_err from receiver;
// tx_dat/tx_stb/tx_busy to transmitter; mem_addr/mem_wdat/mem_we RAM write
// port; cpu_hold keeps CPU in reset; busy high outside IDLE.
import loader_pkg::*;

module serial_loader #(
    parameter int         timeout_cycles = 1600000,
    parameter logic       hold_at_reset  = 1'b1,
    parameter logic [7:0] sync_byte      = SYNC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_dat,
    input  logic        rx_stb,
    input  logic        rx_err,
    output logic [7:0]  tx_dat,
    output logic        tx_stb,
    input  logic        tx_busy,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdat,
    output logic        mem_we,
    output logic        cpu_hold,
    output logic        busy
);

    state_t      state, state_n;
    logic [15:0] addr, addr_n;
    logic [8:0]  len, len_n;
    logic [7:0]  sum, sum_n;
    logic [7:0]  total;
    logic [7:0]  resp, resp_n;
    logic        hold_n;
    logic [15:0] mem_addr_n;
    logic [7:0]  mem_wdat_n;
    logic        mem_we_n;
    logic [7:0]  tx_dat_n;
    logic        tx_stb_n;
    logic        byte_ok;
    logic        active;
    logic        expired;

    // A byte flagged with a framing error is never accepted.
    assign byte_ok = rx_stb && !rx_err;
    assign active  = (state != IDLE) && (state != RESP);
    assign busy    = (state != IDLE);
    assign total   = sum + rx_dat;

    loader_timeout #(
        .timeout_cycles(timeout_cycles)
    ) u_timeout (
        .clk    (clk),
        .reset  (reset),
        .reload (byte_ok),
        .enable (active),
        .expired(expired)
    );

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        len_n      = len;
        sum_n      = sum;
        resp_n     = resp;
        hold_n     = cpu_hold;
        mem_addr_n = mem_addr;
        mem_wdat_n = mem_wdat;
        mem_we_n   = 1'b0;
        tx_dat_n   = tx_dat;
        tx_stb_n   = 1'b0;

        if (active && rx_err) begin
            state_n = IDLE;
        end else if (active && !byte_ok && expired) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (byte_ok && rx_dat == sync_byte) begin
                        state_n = CMD;
                    end
                end
                CMD: begin
                    if (byte_ok) begin
                        state_n = RESP;
                        resp_n  = NAK;
                        if (rx_dat == CMD_LOAD) begin
                            if (cpu_hold) begin
                                state_n = ADDR_H;
                            end
                        end else if (rx_dat == CMD_GO) begin
                            hold_n = 1'b0;
                            resp_n = ACK;
                        end else if (rx_dat == CMD_HOLD) begin
                            hold_n = 1'b1;
                            resp_n = ACK;
                        end
                    end
                end
                ADDR_H: begin
                    if (byte_ok) begin
                        addr_n[15:8] = rx_dat;
                        sum_n        = rx_dat;
                        state_n      = ADDR_L;
                    end
                end
                ADDR_L: begin
                    if (byte_ok) begin
                        addr_n[7:0] = rx_dat;
                        sum_n       = total;
                        state_n     = LEN;
                    end
                end
                LEN: begin
                    if (byte_ok) begin
                        len_n   = (rx_dat == 8'h00) ? 9'd256 : {1'b0, rx_dat};
                        sum_n   = total;
                        state_n = DATA;
                    end
                end
                DATA: begin
                    if (byte_ok) begin
                        mem_addr_n = addr;
                        mem_wdat_n = rx_dat;
                        mem_we_n   = 1'b1;
                        addr_n     = addr + 16'd1;
                        sum_n      = total;
                        len_n      = len - 9'd1;
                        if (len == 9'd1) begin
                            state_n = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (byte_ok) begin
                        resp_n  = (total == 8'h00) ? ACK : NAK;
                        state_n = RESP;
                    end
                end
                RESP: begin
                    if (!tx_busy) begin
                        tx_dat_n = resp;
                        tx_stb_n = 1'b1;
                        state_n  = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            addr     <= '0;
            len      <= '0;
            sum      <= '0;
            resp     <= '0;
            cpu_hold <= hold_at_reset;
            mem_addr <= '0;
            mem_wdat <= '0;
            mem_we   <= 1'b0;
            tx_dat   <= '0;
            tx_stb   <= 1'b0;
        end else begin
            state    <= state_n;
            addr     <= addr_n;
            len      <= len_n;
            sum      <= sum_n;
            resp     <= resp_n;
            cpu_hold <= hold_n;
            mem_addr <= mem_addr_n;
            mem_wdat <= mem_wdat_n;
            mem_we   <= mem_we_n;
            tx_dat   <= tx_dat_n;
            tx_stb   <= tx_stb_n;
        end
    end

endmodule
